// File: rtl/tod_transmitter_pkg.sv
// tod_transmitter_pkg: shared event-code constants, TOD widths and the shift-code helper
package tod_transmitter_pkg;
  localparam logic [7:0] EVCODE_SHIFT_ZERO = 8'h70;
  localparam logic [7:0] EVCODE_SHIFT_ONE = 8'h71;
  localparam logic [7:0] EVCODE_SECONDS_MARKER = 8'h7D;
  localparam int unsigned TOD_SECONDS_WIDTH = 32;
  localparam int unsigned TOD_DELAY = 32;
  localparam int unsigned BIT_GAP = 2;
  localparam int unsigned BITS_W = $clog2(TOD_SECONDS_WIDTH + 1);
  function automatic logic [7:0] shift_code(input logic b);
    return b ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
  endfunction
endpackage

// File: rtl/tod_shifter.sv
// tod_shifter: seconds shift register, bit counter and delay/gap wait counter (load/advance/arm in, msb/last/done/wait_done out)
module tod_shifter
  import tod_transmitter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [TOD_SECONDS_WIDTH-1:0] load_value,
  input  logic                         advance,
  input  logic                         arm,
  input  logic [31:0]                  arm_value,
  output logic                         msb,
  output logic                         next_msb,
  output logic                         last,
  output logic                         done,
  output logic                         wait_done
);
  logic [TOD_SECONDS_WIDTH-1:0] shift_q, shift_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [31:0] wait_q, wait_d;
  always_comb begin
    shift_d = load ? load_value : advance ? {shift_q[TOD_SECONDS_WIDTH-2:0], 1'b0} : shift_q;
    bits_d = load ? BITS_W'(TOD_SECONDS_WIDTH) : advance ? bits_q - BITS_W'(1) : bits_q;
    wait_d = arm ? arm_value : wait_q != 32'd0 ? wait_q - 32'd1 : wait_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bits_q <= '0;
      wait_q <= '0;
    end else begin
      shift_q <= shift_d;
      bits_q <= bits_d;
      wait_q <= wait_d;
    end
  end
  assign msb = shift_q[TOD_SECONDS_WIDTH-1];
  assign next_msb = shift_q[TOD_SECONDS_WIDTH-2];
  assign last = bits_q == BITS_W'(1);
  assign done = bits_q == '0;
  assign wait_done = wait_q == 32'd0;
endmodule

// File: rtl/tod_transmitter.sv
// tod_transmitter: on PPS emits seconds marker, delay, then next seconds MSB-first as shift codes (pps/load in, evCode valid/ready out, seconds/busy/early count out)
module tod_transmitter
  import tod_transmitter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ppsStrobe,
  input  logic                         secondsLoadValid,
  input  logic [TOD_SECONDS_WIDTH-1:0] secondsLoadValue,
  output logic [7:0]                   evCode,
  output logic                         evCodeValid,
  input  logic                         evCodeReady,
  output logic [TOD_SECONDS_WIDTH-1:0] seconds,
  output logic                         busy,
  output logic [15:0]                  ppsEarlyCounter
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MARKER = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_GAP = 3'd4;
  localparam logic [31:0] DELAY_M1 = 32'(TOD_DELAY - 1);
  localparam logic [31:0] GAP_M1 = 32'(BIT_GAP - 1);
  logic [2:0] state_q, state_d;
  logic [7:0] code_q, code_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic [TOD_SECONDS_WIDTH-1:0] seconds_q, seconds_d, next_value;
  logic [15:0] early_q, early_d;
  logic sh_adv, sh_arm, msb, next_msb, last, done, wait_done, accept;
  logic [31:0] sh_arm_val;
  assign accept = valid_q && evCodeReady;
  assign next_value = secondsLoadValid ? secondsLoadValue : seconds_q + 1'b1;
  tod_shifter u_shifter (
    .clk(clk), .rst(rst), .load(ppsStrobe), .load_value(next_value), .advance(sh_adv),
    .arm(sh_arm), .arm_value(sh_arm_val), .msb(msb), .next_msb(next_msb), .last(last),
    .done(done), .wait_done(wait_done)
  );
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    valid_d = valid_q;
    sh_adv = 1'b0;
    sh_arm = 1'b0;
    sh_arm_val = '0;
    seconds_d = ppsStrobe || secondsLoadValid ? next_value : seconds_q;
    early_d = ppsStrobe && state_q != ST_IDLE && early_q != 16'hFFFF ? early_q + 16'd1 : early_q;
    if (ppsStrobe) begin
      state_d = ST_MARKER;
      code_d = EVCODE_SECONDS_MARKER;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_MARKER: if (accept) begin
          sh_arm = 1'b1;
          sh_arm_val = DELAY_M1;
          state_d = TOD_DELAY == 0 ? ST_SHIFT : ST_DELAY;
          valid_d = TOD_DELAY == 0;
          code_d = TOD_DELAY == 0 ? shift_code(msb) : code_q;
        end
        ST_DELAY: if (wait_done) begin
          state_d = ST_SHIFT;
          valid_d = 1'b1;
          code_d = shift_code(msb);
        end
        ST_SHIFT: if (accept) begin
          sh_adv = 1'b1;
          sh_arm = 1'b1;
          sh_arm_val = GAP_M1;
          state_d = BIT_GAP != 0 ? ST_GAP : last ? ST_IDLE : ST_SHIFT;
          valid_d = BIT_GAP == 0 && !last;
          code_d = BIT_GAP == 0 && !last ? shift_code(next_msb) : code_q;
        end
        ST_GAP: if (wait_done) begin
          state_d = done ? ST_IDLE : ST_SHIFT;
          valid_d = !done;
          code_d = done ? code_q : shift_code(msb);
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      seconds_q <= '0;
      early_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      seconds_q <= seconds_d;
      early_q <= early_d;
    end
  end
  assign evCode = code_q;
  assign evCodeValid = valid_q;
  assign busy = busy_q;
  assign seconds = seconds_q;
  assign ppsEarlyCounter = early_q;
endmodule

// File: tb/tb_tod_transmitter.sv
// tb_tod_transmitter: scoreboard bench for tod_transmitter
module tb_tod_transmitter;
  logic clk = 1'b0;
  logic rst, ppsStrobe, secondsLoadValid, evCodeValid, evCodeReady, busy;
  logic [31:0] secondsLoadValue, seconds;
  logic [7:0] evCode;
  logic [15:0] ppsEarlyCounter;
  tod_transmitter dut (
    .clk(clk), .rst(rst), .ppsStrobe(ppsStrobe), .secondsLoadValid(secondsLoadValid),
    .secondsLoadValue(secondsLoadValue), .evCode(evCode), .evCodeValid(evCodeValid),
    .evCodeReady(evCodeReady), .seconds(seconds), .busy(busy), .ppsEarlyCounter(ppsEarlyCounter)
  );
  always #5 clk = ~clk;
  localparam int S_VAL = 0, S_CODE = 1, S_VALID = 2, S_BUSY = 3, S_SECS = 4, S_EARLY = 5;
  typedef struct {string name; int sel; logic [31:0] act; logic [31:0] exp;} chk_t;
  chk_t cq[$];
  logic [7:0] sb[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, n_shift = 0;
  logic pv = 1'b0, pr = 1'b0, have_acc = 1'b0, bp = 1'b0;
  logic [7:0] pc = '0, acc_code = '0;
  logic [31:0] model_secs = '0;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] a;
    cyc++;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      case (c.sel)
        S_CODE: a = {24'h0, evCode};
        S_VALID: a = {31'h0, evCodeValid};
        S_BUSY: a = {31'h0, busy};
        S_SECS: a = seconds;
        S_EARLY: a = {16'h0, ppsEarlyCounter};
        default: a = c.act;
      endcase
      cmp(c.name, a, c.exp);
    end
    if (rst) have_acc = 1'b0;
    else begin
      if (bp && pv && !pr) cmp("stall_hold", {23'h0, evCodeValid, evCode}, {23'h0, 1'b1, pc});
      if (evCodeValid && !pv && evCode != 8'h7D && have_acc)
        cmp("gap_cycles", cyc - acc_cyc, acc_code == 8'h7D ? 33 : 3);
      if (evCodeValid && evCodeReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_code: got %h expected none", evCode);
        end else cmp("code", {24'h0, evCode}, {24'h0, sb.pop_front()});
        acc_cyc = cyc;
        acc_code = evCode;
        have_acc = 1'b1;
        if (evCode != 8'h7D) n_shift++;
      end
    end
    pv = evCodeValid;
    pr = evCodeReady;
    pc = evCode;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_(input string n, input int sel, input logic [31:0] v, input logic [31:0] e);
    cq.push_back('{n, sel, v, e});
  endtask
  task automatic pps(input logic ld, input logic [31:0] v);
    model_secs = ld ? v : model_secs + 32'd1;
    sb.delete();
    sb.push_back(8'h7D);
    for (int i = 31; i >= 0; i--) sb.push_back(model_secs[i] ? 8'h71 : 8'h70);
    ppsStrobe = 1'b1;
    secondsLoadValid = ld;
    secondsLoadValue = v;
    tick;
    ppsStrobe = 1'b0;
    secondsLoadValid = 1'b0;
    expect_("marker_valid", S_VALID, 0, 1);
    expect_("marker_code", S_CODE, 0, 32'h7D);
    expect_("busy_set", S_BUSY, 0, 1);
    expect_("seconds_at_pps", S_SECS, 0, model_secs);
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick;
      if (bp) evCodeReady = 1'($urandom_range(0, 1));
      n++;
    end
    expect_("idle_reached", S_VAL, {31'h0, busy}, 0);
    expect_("sb_drained", S_VAL, sb.size(), 0);
  endtask
  task automatic wait_shifts(input int k, input int bound);
    int base = n_shift;
    int n = 0;
    while (n_shift - base < k && n < bound) begin
      tick;
      n++;
    end
    expect_("shift_progress", S_VAL, n_shift - base, k);
  endtask
  initial begin
    int n, vcnt;
    rst = 1'b1;
    ppsStrobe = 1'b0;
    secondsLoadValid = 1'b0;
    secondsLoadValue = '0;
    evCodeReady = 1'b1;
    repeat (3) tick;
    expect_("rst_valid", S_VALID, 0, 0);
    expect_("rst_code", S_CODE, 0, 0);
    expect_("rst_busy", S_BUSY, 0, 0);
    expect_("rst_early", S_EARLY, 0, 0);
    expect_("rst_seconds", S_SECS, 0, 0);
    rst = 1'b0;
    tick;
    pps(1'b1, 32'h12345677);
    wait_idle(300);
    expect_("seconds_load_pps", S_SECS, 0, 32'h12345677);
    repeat (5) tick;
    pps(1'b0, 32'h0);
    wait_idle(300);
    expect_("seconds_incr", S_SECS, 0, 32'h12345678);
    pps(1'b0, 32'h0);
    bp = 1'b1;
    wait_idle(3000);
    bp = 1'b0;
    evCodeReady = 1'b1;
    expect_("seconds_bp", S_SECS, 0, 32'h12345679);
    tick;
    pps(1'b0, 32'h0);
    wait_shifts(10, 500);
    evCodeReady = 1'b0;
    n = 0;
    while (!evCodeValid && n < 20) begin
      tick;
      n++;
    end
    expect_("bit10_presented", S_VAL, {31'h0, evCodeValid}, 1);
    pps(1'b0, 32'h0);
    evCodeReady = 1'b1;
    expect_("early_count", S_EARLY, 0, 1);
    expect_("seconds_abort", S_SECS, 0, 32'h1234567B);
    wait_idle(300);
    secondsLoadValid = 1'b1;
    secondsLoadValue = 32'hCAFEF00D;
    model_secs = 32'hCAFEF00D;
    tick;
    secondsLoadValid = 1'b0;
    expect_("load_only_seconds", S_SECS, 0, 32'hCAFEF00D);
    expect_("load_only_idle", S_BUSY, 0, 0);
    tick;
    pps(1'b0, 32'h0);
    wait_shifts(5, 300);
    rst = 1'b1;
    sb.delete();
    model_secs = '0;
    tick;
    rst = 1'b0;
    expect_("midrst_valid", S_VALID, 0, 0);
    expect_("midrst_code", S_CODE, 0, 0);
    expect_("midrst_busy", S_BUSY, 0, 0);
    expect_("midrst_seconds", S_SECS, 0, 0);
    expect_("midrst_early", S_EARLY, 0, 0);
    vcnt = 0;
    repeat (150) begin
      tick;
      if (evCodeValid) vcnt++;
    end
    expect_("no_codes_after_rst", S_VAL, vcnt, 0);
    tick;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
